arq_ecc_fifo: RTL and testbench

ARQ_ECC_FIFO -- requirements
Module: arq_ecc_fifo

---
 rtl/arq_ecc_pkg.sv | 107 ++++++++++
 rtl/arq_ecc_fifo_secded_codec.sv | 21 ++
 rtl/arq_ecc_fifo.sv | 188 ++++++++++++++++++
 tb/tb_arq_ecc_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/arq_ecc_pkg.sv
// Shared types and SEC-DED helpers for the ARQ FIFO.
// Functions work on the widest supported payload; callers size-cast the results.
package arq_ecc_pkg;

  localparam int MAX_DW    = 16;
  localparam int MAX_P     = 5;
  localparam int MAX_CW    = MAX_DW + MAX_P + 1;
  localparam int MAX_DW_AW = $clog2(MAX_DW);
  localparam int MAX_CW_AW = $clog2(MAX_CW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2
  } arq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'b00,
    ERR_SINGLE      = 2'b01,
    ERR_DOUBLE      = 2'b10,
    ERR_DOUBLE_ONCE = 2'b11
  } err_mode_e;

  // Flags sit in the LSBs so a (DATA_W+2)-bit cast keeps data and both flags.
  typedef struct packed {
    logic [MAX_DW-1:0] data;
    logic              single_err;
    logic              double_err;
  } dec_res_t;

  function automatic int ecc_parity_bits(input int dw);
    int p;
    p = MAX_P;
    for (int k = MAX_P; k >= 1; k--) begin
      if ((1 << k) >= dw + k + 1) p = k;
    end
    return p;
  endfunction

  // Bit 0 is overall parity; bits 1..n follow Hamming positions.
  function automatic logic [MAX_CW-1:0] ecc_encode(input logic [MAX_DW-1:0] data, input int dw);
    logic [MAX_CW-1:0] cw;
    int                np;
    int                n;
    int                di;
    logic              b;
    np = ecc_parity_bits(dw);
    n  = dw + np;
    di = 0;
    cw = '0;
    for (int pos = 1; pos < MAX_CW; pos++) begin
      if (pos <= n && (pos & (pos - 1)) != 0) begin
        cw[MAX_CW_AW'(pos)] = data[MAX_DW_AW'(di)];
        di = di + 1;
      end
    end
    for (int k = 0; k < MAX_P; k++) begin
      if (k < np) begin
        b = 1'b0;
        for (int pos = 1; pos < MAX_CW; pos++) begin
          if (pos <= n && ((pos >> k) & 1) != 0) b = b ^ cw[MAX_CW_AW'(pos)];
        end
        cw[MAX_CW_AW'(1 << k)] = b;
      end
    end
    cw[0] = ^cw[MAX_CW-1:1];
    return cw;
  endfunction

  function automatic dec_res_t ecc_decode(input logic [MAX_CW-1:0] cw_in, input int dw);
    dec_res_t          res;
    logic [MAX_CW-1:0] cw;
    int                np;
    int                n;
    int                di;
    int                syn;
    logic              overall;
    logic              b;
    np      = ecc_parity_bits(dw);
    n       = dw + np;
    cw      = cw_in;
    syn     = 0;
    overall = ^cw_in;
    for (int k = 0; k < MAX_P; k++) begin
      if (k < np) begin
        b = 1'b0;
        for (int pos = 1; pos < MAX_CW; pos++) begin
          if (pos <= n && ((pos >> k) & 1) != 0) b = b ^ cw[MAX_CW_AW'(pos)];
        end
        if (b) syn = syn | (1 << k);
      end
    end
    res.single_err = overall;
    res.double_err = !overall && (syn != 0);
    if (overall && syn != 0 && syn <= n) cw[MAX_CW_AW'(syn)] = ~cw[MAX_CW_AW'(syn)];
    res.data = '0;
    di = 0;
    for (int pos = 1; pos < MAX_CW; pos++) begin
      if (pos <= n && (pos & (pos - 1)) != 0) begin
        res.data[MAX_DW_AW'(di)] = cw[MAX_CW_AW'(pos)];
        di = di + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arq_ecc_fifo_secded_codec.sv
// Combinational extended-Hamming encoder and decoder for one payload width.
module secded_codec
  import arq_ecc_pkg::*;
#(
  parameter  int DATA_W = 4,
  localparam int CW     = DATA_W + ecc_parity_bits(DATA_W) + 1
) (
  input  logic [DATA_W-1:0] i_enc_data,
  output logic [CW-1:0]     o_enc_cw,
  input  logic [CW-1:0]     i_dec_cw,
  output logic [DATA_W-1:0] o_dec_data,
  output logic              o_dec_single,
  output logic              o_dec_double
);

  assign o_enc_cw = CW'(ecc_encode(MAX_DW'(i_enc_data), DATA_W));

  assign {o_dec_data, o_dec_single, o_dec_double} =
    (DATA_W + 2)'(ecc_decode(MAX_CW'(i_dec_cw), DATA_W));

endmodule

// File: rtl/arq_ecc_fifo.sv
// SEC-DED protected FIFO with bounded re-read on uncorrectable errors.
// Reads run IDLE -> READ -> CHECK; a double error sends the FSM back to READ.
module arq_ecc_fifo
  import arq_ecc_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [DATA_W-1:0]              data_in,
  input  logic [1:0]                     err_mode,
  output logic [DATA_W-1:0]              data_out,
  output logic                           ack,
  output logic                           nack,
  output logic                           corr,
  output logic                           fail,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int CW = DATA_W + ecc_parity_bits(DATA_W) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(DEPTH);
  localparam logic [RW-1:0] RETRY_ONE  = RW'(1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [CW-1:0] MASK_BIT0  = CW'(1);
  localparam logic [CW-1:0] MASK_BIT01 = CW'(3);

  logic [CW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [AW:0]       w_count_nxt;
  arq_state_e        r_state;
  arq_state_e        w_state_nxt;
  logic [CW-1:0]     r_cw;
  logic [CW-1:0]     w_wr_cw;
  logic [CW-1:0]     w_mask;
  logic [DATA_W-1:0] w_dec_data;
  logic              w_dec_single;
  logic              w_dec_double;
  logic [DATA_W-1:0] r_data_out;
  logic              r_ack;
  logic              r_nack;
  logic              r_corr;
  logic              r_fail;
  logic              r_full;
  logic              r_empty;
  logic [RW-1:0]     r_retry;
  logic              w_push;
  logic              w_pop;
  logic              w_ack;
  logic              w_nack;
  logic              w_corr;
  logic              w_fail;
  logic              w_retry_inc;

  secded_codec #(.DATA_W(DATA_W)) u_codec (
    .i_enc_data   (data_in),
    .o_enc_cw     (w_wr_cw),
    .i_dec_cw     (r_cw),
    .o_dec_data   (w_dec_data),
    .o_dec_single (w_dec_single),
    .o_dec_double (w_dec_double)
  );

  assign w_push = wr_en && !r_full;

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_cw;
  end

  always_comb begin
    w_mask = '0;
    case (err_mode)
      ERR_NONE:        w_mask = '0;
      ERR_SINGLE:      w_mask = MASK_BIT0;
      ERR_DOUBLE:      w_mask = MASK_BIT01;
      ERR_DOUBLE_ONCE: begin
        if (r_retry == '0) w_mask = MASK_BIT01;
        else               w_mask = '0;
      end
      default:         w_mask = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus the one-cycle strobes that get registered below.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_ack       = 1'b0;
    w_nack      = 1'b0;
    w_corr      = 1'b0;
    w_fail      = 1'b0;
    w_retry_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rd_en && !r_empty) w_state_nxt = ST_READ;
        else                   w_state_nxt = ST_IDLE;
      end
      ST_READ: w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (w_dec_double) begin
          w_nack = 1'b1;
          if (r_retry < RETRY_MAX) begin
            w_retry_inc = 1'b1;
            w_state_nxt = ST_READ;
          end else begin
            w_fail      = 1'b1;
            w_pop       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_ack       = 1'b1;
          w_corr      = w_dec_single;
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_cw       <= '0;
      r_retry    <= '0;
      r_data_out <= '0;
      r_ack      <= 1'b0;
      r_nack     <= 1'b0;
      r_corr     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
      if (r_state == ST_READ) r_cw <= r_mem[r_rd_ptr] ^ w_mask;
      if (w_pop)            r_retry <= '0;
      else if (w_retry_inc) r_retry <= r_retry + RETRY_ONE;
      if (w_ack) r_data_out <= w_dec_data;
      r_ack  <= w_ack;
      r_nack <= w_nack;
      r_corr <= w_corr;
      r_fail <= w_fail;
    end
  end

  assign data_out  = r_data_out;
  assign ack       = r_ack;
  assign nack      = r_nack;
  assign corr      = r_corr;
  assign fail      = r_fail;
  assign full      = r_full;
  assign empty     = r_empty;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_arq_ecc_fifo.sv
// Scoreboard bench for arq_ecc_fifo (DATA_W=4, DEPTH=8, MAX_RETRY=3).
module tb_arq_ecc_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] data_in;
  logic [1:0] err_mode;
  logic [3:0] data_out;
  logic       ack;
  logic       nack;
  logic       corr;
  logic       fail;
  logic       full;
  logic       empty;
  logic [1:0] retry_cnt;

  always #5 clk = ~clk;

  arq_ecc_fifo #(.DATA_W(4), .DEPTH(8), .MAX_RETRY(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .data_in   (data_in),
    .err_mode  (err_mode),
    .data_out  (data_out),
    .ack       (ack),
    .nack      (nack),
    .corr      (corr),
    .fail      (fail),
    .full      (full),
    .empty     (empty),
    .retry_cnt (retry_cnt)
  );

  typedef struct {
    int         cyc;
    logic       ack;
    logic       nack;
    logic       fail;
    logic       corr;
    logic [3:0] dout;
    logic [1:0] retry;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] model_q[$];
  logic [3:0] exp_dout;
  exp_t       mon_e;
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pop one expected event per observed pulse.
  always @(negedge clk) begin
    if (ack === 1'b1 || nack === 1'b1 || fail === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_pulse", 32'({ack, nack, fail}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("cycle", 32'(cyc), 32'(mon_e.cyc));
        check_val("ack", 32'(ack), 32'(mon_e.ack));
        check_val("nack", 32'(nack), 32'(mon_e.nack));
        check_val("fail", 32'(fail), 32'(mon_e.fail));
        check_val("corr", 32'(corr), 32'(mon_e.corr));
        check_val("data_out", 32'(data_out), 32'(mon_e.dout));
        check_val("retry_cnt", 32'(retry_cnt), 32'(mon_e.retry));
      end
    end
  end

  task automatic push_ev(input int c, input logic a, input logic n, input logic f,
                         input logic cr, input logic [3:0] d, input logic [1:0] r);
    exp_t e;
    e.cyc = c; e.ack = a; e.nack = n; e.fail = f; e.corr = cr; e.dout = d; e.retry = r;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic wr(input logic [3:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    data_in = d;
    if (model_q.size() < 8) model_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] mode, input bit wr_mid, input logic [3:0] wd);
    logic [3:0] v;
    int         s;
    @(negedge clk);
    s = cyc + 1;
    v = model_q.pop_front();
    case (mode)
      2'b00: begin push_ev(s + 2, 1'b1, 1'b0, 1'b0, 1'b0, v, 2'd0); exp_dout = v; end
      2'b01: begin push_ev(s + 2, 1'b1, 1'b0, 1'b0, 1'b1, v, 2'd0); exp_dout = v; end
      2'b10: begin
        for (int i = 1; i <= 3; i++) push_ev(s + 2 * i, 1'b0, 1'b1, 1'b0, 1'b0, exp_dout, 2'(i));
        push_ev(s + 8, 1'b0, 1'b1, 1'b1, 1'b0, exp_dout, 2'd0);
      end
      default: begin
        push_ev(s + 2, 1'b0, 1'b1, 1'b0, 1'b0, exp_dout, 2'd1);
        push_ev(s + 4, 1'b1, 1'b0, 1'b0, 1'b0, v, 2'd0);
        exp_dout = v;
      end
    endcase
    err_mode = mode;
    rd_en    = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (wr_mid) begin
      @(negedge clk);
      wr_en   = 1'b1;
      data_in = wd;
      model_q.push_back(wd);
      @(negedge clk);
      wr_en = 1'b0;
    end
    drain();
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_data_out"}, 32'(data_out), 32'd0);
    check_val({tag, "_pulses"}, 32'({ack, nack, corr, fail}), 32'd0);
    check_val({tag, "_empty"}, 32'(empty), 32'd1);
    check_val({tag, "_full"}, 32'(full), 32'd0);
    check_val({tag, "_retry"}, 32'(retry_cnt), 32'd0);
  endtask

  initial begin
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    data_in  = 4'h0;
    err_mode = 2'b00;
    rst_n    = 1'b0;
    exp_dout = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset("reset");

    wr(4'hA); rd(2'b00, 1'b0, 4'h0);
    check_val("clean_empty", 32'(empty), 32'd1);
    wr(4'h5); rd(2'b01, 1'b0, 4'h0);
    wr(4'h3); rd(2'b10, 1'b0, 4'h0);
    check_val("drop_empty", 32'(empty), 32'd1);
    wr(4'hC); rd(2'b11, 1'b0, 4'h0);
    check_val("once_retry", 32'(retry_cnt), 32'd0);

    for (int i = 0; i < 8; i++) wr(4'(i));
    check_val("fill_full", 32'(full), 32'd1);
    check_val("fill_empty", 32'(empty), 32'd0);
    wr(4'hF);
    check_val("overflow_full", 32'(full), 32'd1);
    rd(2'b00, 1'b0, 4'h0);
    check_val("after_pop_full", 32'(full), 32'd0);
    rd(2'b00, 1'b1, 4'hE);
    check_val("wr_pop_full", 32'(full), 32'd0);
    wr(4'hD);
    check_val("refill_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) rd(2'b00, 1'b0, 4'h0);
    check_val("drain_empty", 32'(empty), 32'd1);
    check_val("drain_full", 32'(full), 32'd0);

    wr(4'h9);
    @(negedge clk);
    void'(model_q.pop_front());
    err_mode = 2'b00;
    rd_en    = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    rst_n    = 1'b1;
    exp_dout = 4'h0;
    model_q.delete();
    repeat (3) @(negedge clk);
    check_val("mid_reset_quiet", 32'({ack, nack, fail}), 32'd0);

    wr(4'h6); rd(2'b01, 1'b0, 4'h0);
    check_val("post_reset_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
